mem_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer in front of `memory_controller`. It shares the controller's single 16-bit bus between two requesters: port 0 is the CPU and port 1 is a DMA or video-fetch engine. It holds `read_en`/`write_en` for a fixed number of cycles so the controller can complete its two-byte SRAM transfer. It then forces an idle gap so the controller resets its byte counter before the next access.

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences fixed-length accesses onto the
// shared SRAM memory controller bus, with a forced idle gap after each access.
module mem_arbiter #(
   parameter int ACCESS_CYCLES = 3,
   parameter int IDLE_GAP      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [15:0] m0_addr,
   input  logic [15:0] m0_wdata,
   output logic        m0_ack,
   output logic [15:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [15:0] m1_addr,
   input  logic [15:0] m1_wdata,
   output logic        m1_ack,
   output logic [15:0] m1_rdata,
   output logic [15:0] mc_address,
   output logic [15:0] mc_data_in,
   input  logic [15:0] mc_data_out,
   output logic        mc_read_en,
   output logic        mc_write_en
);

   localparam int CNT_MAX = (ACCESS_CYCLES > IDLE_GAP) ? ACCESS_CYCLES : IDLE_GAP;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] ACC_LOAD = CW'(ACCESS_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'(IDLE_GAP - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_req_any;
   logic            w_grant;
   logic            w_start;
   logic            w_done;
   logic            r_grant;
   logic            r_last_grant;
   logic            r_we;
   logic [15:0]     r_mc_address;
   logic [15:0]     r_mc_data_in;
   logic            r_m0_ack;
   logic            r_m1_ack;
   logic [15:0]     r_m0_rdata;
   logic [15:0]     r_m1_rdata;

   assign w_req_any = m0_req | m1_req;

   // Round-robin pick: under contention the port that did not win last time goes next.
   always_comb begin
      w_grant = 1'b0;
      if (m0_req && m1_req) begin
         w_grant = ~r_last_grant;
      end else if (m1_req) begin
         w_grant = 1'b1;
      end else begin
         w_grant = 1'b0;
      end
   end

   // Next-state and cycle counter for the IDLE -> ACCESS -> GAP sequence.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_start     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               w_state_nxt = ST_ACCESS;
               w_cnt_nxt   = ACC_LOAD;
               w_start     = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt;
            end
         end
         ST_ACCESS: begin
            if (r_cnt == CNT_ZERO) begin
               w_state_nxt = ST_GAP;
               w_cnt_nxt   = GAP_LOAD;
               w_done      = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt - CNT_ONE;
            end
         end
         ST_GAP: begin
            if (r_cnt == CNT_ZERO) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt   = r_cnt - CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= CNT_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Latch the winner's request at grant; held on the bus until the next grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mc_address <= 16'h0000;
         r_mc_data_in <= 16'h0000;
         r_we         <= 1'b0;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_start) begin
         r_mc_address <= w_grant ? m1_addr  : m0_addr;
         r_mc_data_in <= w_grant ? m1_wdata : m0_wdata;
         r_we         <= w_grant ? m1_we    : m0_we;
         r_grant      <= w_grant;
         r_last_grant <= w_grant;
      end
   end

   // Completion pulse and read-data capture on the edge that leaves ACCESS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m0_ack   <= 1'b0;
         r_m1_ack   <= 1'b0;
         r_m0_rdata <= 16'h0000;
         r_m1_rdata <= 16'h0000;
      end else begin
         r_m0_ack <= w_done & ~r_grant;
         r_m1_ack <= w_done & r_grant;
         if (w_done && !r_we && !r_grant) begin
            r_m0_rdata <= mc_data_out;
         end
         if (w_done && !r_we && r_grant) begin
            r_m1_rdata <= mc_data_out;
         end
      end
   end

   // Enables follow the state directly so they drop in the cycle ACCESS ends.
   assign mc_read_en  = (r_state == ST_ACCESS) && !r_we;
   assign mc_write_en = (r_state == ST_ACCESS) && r_we;
   assign mc_address  = r_mc_address;
   assign mc_data_in  = r_mc_data_in;
   assign m0_ack      = r_m0_ack;
   assign m1_ack      = r_m1_ack;
   assign m0_rdata    = r_m0_rdata;
   assign m1_rdata    = r_m1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-timing reference model.
module tb_mem_arbiter;

   localparam int A = 3;
   localparam int G = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
   logic [15:0] m0_addr = 16'h0000, m1_addr = 16'h0000;
   logic [15:0] m0_wdata = 16'h0000, m1_wdata = 16'h0000, mc_data_out = 16'h0000;
   logic        m0_ack, m1_ack, mc_read_en, mc_write_en;
   logic [15:0] m0_rdata, m1_rdata, mc_address, mc_data_in;
   logic        d2_m0_ack, d2_m1_ack, d2_rd, d2_wr;
   logic [15:0] d2_m0_rdata, d2_m1_rdata, d2_addr, d2_data_in;

   int checks = 0;
   int passes = 0;

   mem_arbiter #(.ACCESS_CYCLES(A), .IDLE_GAP(G)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mc_address(mc_address), .mc_data_in(mc_data_in), .mc_data_out(mc_data_out),
      .mc_read_en(mc_read_en), .mc_write_en(mc_write_en)
   );

   mem_arbiter #(.ACCESS_CYCLES(1), .IDLE_GAP(2)) dut2 (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(d2_m0_ack), .m0_rdata(d2_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(d2_m1_ack), .m1_rdata(d2_m1_rdata),
      .mc_address(d2_addr), .mc_data_in(d2_data_in), .mc_data_out(mc_data_out),
      .mc_read_en(d2_rd), .mc_write_en(d2_wr)
   );

   always #5 clk = ~clk;

   // Reference model: each grant at edge s owns cycles s+1..s+A (enable),
   // acks in cycle s+A+1 and frees the bus for a new grant at edge s+A+G+1.
   int          cyc = 0;
   int          m_start = 0;
   logic        m_active = 1'b0, m_port = 1'b0, m_we = 1'b0, m_last = 1'b1;
   logic [15:0] m_addr = 16'h0000, m_data = 16'h0000, m_rd0 = 16'h0000, m_rd1 = 16'h0000;
   logic        exp_en, exp_rd, exp_wr, exp_ack0, exp_ack1;

   function automatic logic pick(input logic r0, input logic r1, input logic last);
      if (r0 && r1) return ~last;
      return r1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_last   <= 1'b1;
         m_addr   <= 16'h0000;
         m_data   <= 16'h0000;
         m_rd0    <= 16'h0000;
         m_rd1    <= 16'h0000;
      end else begin
         if (m_active && cyc == m_start + A && !m_we) begin
            if (m_port) m_rd1 <= mc_data_out;
            else        m_rd0 <= mc_data_out;
         end
         if ((!m_active || cyc >= m_start + A + G + 1) && (m0_req || m1_req)) begin
            m_port   <= pick(m0_req, m1_req, m_last);
            m_last   <= pick(m0_req, m1_req, m_last);
            m_we     <= pick(m0_req, m1_req, m_last) ? m1_we : m0_we;
            m_addr   <= pick(m0_req, m1_req, m_last) ? m1_addr : m0_addr;
            m_data   <= pick(m0_req, m1_req, m_last) ? m1_wdata : m0_wdata;
            m_start  <= cyc;
            m_active <= 1'b1;
         end
      end
   end

   assign exp_en   = m_active && (cyc >= m_start + 1) && (cyc <= m_start + A);
   assign exp_rd   = exp_en && !m_we;
   assign exp_wr   = exp_en && m_we;
   assign exp_ack0 = m_active && (cyc == m_start + A + 1) && !m_port;
   assign exp_ack1 = m_active && (cyc == m_start + A + 1) && m_port;

   task automatic apply_reset();
      m0_req = 1'b0;
      m1_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({mc_read_en, mc_write_en, m0_ack, m1_ack, mc_address, mc_data_in, m0_rdata, m1_rdata} !== 68'h0)
         $display("FAIL reset_main: got %h expected 0",
                  {mc_read_en, mc_write_en, m0_ack, m1_ack, mc_address, mc_data_in, m0_rdata, m1_rdata});
      else passes++;
      checks++;
      if ({d2_rd, d2_wr, d2_m0_ack, d2_m1_ack, d2_addr, d2_data_in, d2_m0_rdata, d2_m1_rdata} !== 68'h0)
         $display("FAIL reset_param: got %h expected 0",
                  {d2_rd, d2_wr, d2_m0_ack, d2_m1_ack, d2_addr, d2_data_in, d2_m0_rdata, d2_m1_rdata});
      else passes++;
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      logic e;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0101; mc_data_out = 16'h4801;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         e = (i <= 3);
         checks++;
         if (mc_read_en !== e || mc_write_en !== 1'b0)
            $display("FAIL single_en c%0d: got rd=%b wr=%b expected rd=%b wr=0", i, mc_read_en, mc_write_en, e);
         else passes++;
         checks++;
         if (m0_ack !== (i == 4) || m1_ack !== 1'b0)
            $display("FAIL single_ack c%0d: got %b%b expected %b0", i, m0_ack, m1_ack, (i == 4));
         else passes++;
         checks++;
         if (mc_address !== 16'h0101)
            $display("FAIL single_addr c%0d: got %h expected 0101", i, mc_address);
         else passes++;
         if (i == 4) begin
            checks++;
            if (m0_rdata !== 16'h4801)
               $display("FAIL single_rdata: got %h expected 4801", m0_rdata);
            else passes++;
            m0_req = 1'b0;
         end
      end
   endtask

   task automatic test_port1_write();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'hF830; m1_wdata = 16'h0748; mc_data_out = 16'hDEAD;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if (mc_write_en !== (i <= 3) || mc_read_en !== 1'b0)
            $display("FAIL write_en c%0d: got wr=%b rd=%b expected wr=%b rd=0", i, mc_write_en, mc_read_en, (i <= 3));
         else passes++;
         checks++;
         if (m1_ack !== (i == 4) || m0_ack !== 1'b0)
            $display("FAIL write_ack c%0d: got m1=%b m0=%b expected m1=%b m0=0", i, m1_ack, m0_ack, (i == 4));
         else passes++;
         checks++;
         if (mc_address !== 16'hF830 || mc_data_in !== 16'h0748)
            $display("FAIL write_bus c%0d: got %h/%h expected f830/0748", i, mc_address, mc_data_in);
         else passes++;
         if (i == 4) begin
            checks++;
            if (m1_rdata !== 16'h0000)
               $display("FAIL write_rdata: got %h expected 0000", m1_rdata);
            else passes++;
            m1_req = 1'b0;
         end
      end
   endtask

   task automatic test_contention();
      apply_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0A0A;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0B0B; m1_wdata = 16'h5A5A;
      mc_data_out = 16'h1357;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         checks++;
         if (m0_ack !== (i == 4) || m1_ack !== (i == 9))
            $display("FAIL contend_ack c%0d: got %b%b expected %b%b", i, m0_ack, m1_ack, (i == 4), (i == 9));
         else passes++;
         checks++;
         if (mc_read_en !== (i <= 3) || mc_write_en !== (i >= 6 && i <= 8))
            $display("FAIL contend_en c%0d: got rd=%b wr=%b", i, mc_read_en, mc_write_en);
         else passes++;
         if (i == 2) begin
            checks++;
            if (mc_address !== 16'h0A0A)
               $display("FAIL contend_addr0: got %h expected 0a0a", mc_address);
            else passes++;
         end
         if (i == 7) begin
            checks++;
            if (mc_address !== 16'h0B0B || mc_data_in !== 16'h5A5A)
               $display("FAIL contend_addr1: got %h/%h expected 0b0b/5a5a", mc_address, mc_data_in);
            else passes++;
         end
         if (i == 4) m0_req = 1'b0;
         if (i == 9) m1_req = 1'b0;
      end
   endtask

   task automatic test_fairness();
      logic p;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h1111;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h2222;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         p = 1'((i / 5) % 2);
         checks++;
         if (mc_read_en !== (((i - 1) % 5) < 3) || mc_write_en !== 1'b0)
            $display("FAIL fair_en c%0d: got rd=%b wr=%b", i, mc_read_en, mc_write_en);
         else passes++;
         checks++;
         if (m0_ack !== ((i % 5 == 4) && !p) || m1_ack !== ((i % 5 == 4) && p))
            $display("FAIL fair_ack c%0d: got %b%b expected port %b", i, m0_ack, m1_ack, p);
         else passes++;
         if (i % 5 == 4) begin
            checks++;
            if (mc_address !== (p ? 16'h2222 : 16'h1111))
               $display("FAIL fair_addr c%0d: got %h", i, mc_address);
            else passes++;
         end
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         checks++;
         if ({mc_read_en, mc_write_en, m0_ack, m1_ack} !== {exp_rd, exp_wr, exp_ack0, exp_ack1})
            $display("FAIL rand_ctl n%0d: got %b expected %b", n,
                     {mc_read_en, mc_write_en, m0_ack, m1_ack}, {exp_rd, exp_wr, exp_ack0, exp_ack1});
         else passes++;
         checks++;
         if (mc_address !== m_addr || mc_data_in !== m_data)
            $display("FAIL rand_bus n%0d: got %h/%h expected %h/%h", n, mc_address, mc_data_in, m_addr, m_data);
         else passes++;
         checks++;
         if (m0_rdata !== m_rd0 || m1_rdata !== m_rd1)
            $display("FAIL rand_rdata n%0d: got %h/%h expected %h/%h", n, m0_rdata, m1_rdata, m_rd0, m_rd1);
         else passes++;
         checks++;
         if ((m0_ack && m1_ack) || (mc_read_en && mc_write_en))
            $display("FAIL rand_excl n%0d: got ack=%b%b en=%b%b expected no overlap", n, m0_ack, m1_ack,
                     mc_read_en, mc_write_en);
         else passes++;
         if (m0_req && m0_ack) m0_req = 1'b0;
         else if (!m0_req) begin
            m0_req = ($urandom_range(0, 2) == 0);
            m0_we = 1'($urandom_range(0, 1)); m0_addr = 16'($urandom); m0_wdata = 16'($urandom);
         end else if ($urandom_range(0, 3) == 0) m0_addr = 16'($urandom);
         if (m1_req && m1_ack) m1_req = 1'b0;
         else if (!m1_req) begin
            m1_req = ($urandom_range(0, 2) == 0);
            m1_we = 1'($urandom_range(0, 1)); m1_addr = 16'($urandom); m1_wdata = 16'($urandom);
         end else if ($urandom_range(0, 3) == 0) m1_wdata = 16'($urandom);
         mc_data_out = 16'($urandom);
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset_mid_access();
      apply_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h3C3C;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      m0_req = 1'b0;
      #1;
      checks++;
      if (mc_read_en !== 1'b0 || mc_write_en !== 1'b0 || mc_address !== 16'h0000)
         $display("FAIL midrst_now: got rd=%b wr=%b addr=%h expected 0/0/0000", mc_read_en, mc_write_en, mc_address);
      else passes++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ({m0_ack, m1_ack, mc_read_en, mc_write_en} !== 4'b0000)
            $display("FAIL midrst_quiet c%0d: got %b expected 0000", i, {m0_ack, m1_ack, mc_read_en, mc_write_en});
         else passes++;
      end
      test_single_read();
   endtask

   task automatic test_params();
      apply_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0042;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0043;
      mc_data_out = 16'h2468;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         checks++;
         if (d2_rd !== (i == 1 || i == 5) || d2_wr !== 1'b0)
            $display("FAIL param_en c%0d: got rd=%b wr=%b", i, d2_rd, d2_wr);
         else passes++;
         checks++;
         if (d2_m0_ack !== (i == 2) || d2_m1_ack !== (i == 6))
            $display("FAIL param_ack c%0d: got %b%b expected %b%b", i, d2_m0_ack, d2_m1_ack, (i == 2), (i == 6));
         else passes++;
         if (i == 2) begin
            checks++;
            if (d2_m0_rdata !== 16'h2468)
               $display("FAIL param_rdata0: got %h expected 2468", d2_m0_rdata);
            else passes++;
            m0_req = 1'b0;
         end
         if (i == 3) mc_data_out = 16'h8642;
         if (i == 6) begin
            checks++;
            if (d2_m1_rdata !== 16'h8642)
               $display("FAIL param_rdata1: got %h expected 8642", d2_m1_rdata);
            else passes++;
            m1_req = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_port1_write();
      test_contention();
      test_fairness();
      test_random();
      test_reset_mid_access();
      test_params();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
